// File: rtl/mem_port_if.sv
// External word-wide req/ack memory bus between mem_port (master) and the memory (slave).
interface mem_port_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_port.sv
// Byte/half/word load-store stage: turns one datapath request into a single
// req/ack bus transaction and returns lane-selected, extended load data.
module mem_port #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data_input,
    output logic [31:0] mem_data_output,
    output logic        busy,
    output logic        done,
    output logic        fault,
    mem_port_if.master  bus
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             state_q, state_d;
    logic               fault_q, fault_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [1:0]         lo_q, lo_d;
    logic [1:0]         size_q, size_d;
    logic               uns_q, uns_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    function automatic logic access_ok(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'd0:    access_ok = 1'b1;
            2'd1:    access_ok = (lo[0] == 1'b0);
            2'd2:    access_ok = (lo == 2'b00);
            default: access_ok = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'd0:    lane_be = 4'b0001 << lo;
            2'd1:    lane_be = 4'b0011 << {lo[1], 1'b0};
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'd0:    lane_wdata = {4{d[7:0]}};
            2'd1:    lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0, then extend to the full word.
    function automatic logic [31:0] load_extract(input logic [31:0] rd, input logic [1:0] lo,
                                                 input logic [1:0] sz, input logic uns);
        logic [31:0] sh;
        sh = rd >> {lo, 3'b000};
        case (sz)
            2'd0:    load_extract = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'd1:    load_extract = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: load_extract = rd;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        lo_d    = lo_q;
        size_d  = size_q;
        uns_d   = uns_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    lo_d   = mem_addr[1:0];
                    size_d = req_size;
                    uns_d  = req_unsigned;
                    if (access_ok(req_size, mem_addr[1:0])) begin
                        state_d = ACCESS;
                        req_d   = 1'b1;
                        we_d    = req_wr;
                        addr_d  = {mem_addr[31:2], 2'b00};
                        be_d    = lane_be(req_size, mem_addr[1:0]);
                        wdata_d = lane_wdata(req_size, mem_data_input);
                        cnt_d   = '0;
                    end else begin
                        state_d = RESP;
                        fault_d = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (bus.bus_ack) begin
                    state_d = RESP;
                    req_d   = 1'b0;
                    fault_d = 1'b0;
                    if (!we_q) rdata_d = load_extract(bus.bus_rdata, lo_q, size_q, uns_q);
                end else if (TIMEOUT > 0) begin
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_d = RESP;
                        req_d   = 1'b0;
                        fault_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                fault_d = 1'b0;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            fault_q <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            lo_q    <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            lo_q    <= lo_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy            = (state_q != IDLE);
    assign done            = (state_q == RESP);
    assign fault           = fault_q;
    assign mem_data_output = rdata_q;
    assign bus.bus_req     = req_q;
    assign bus.bus_we      = we_q;
    assign bus.bus_addr    = addr_q;
    assign bus.bus_be      = be_q;
    assign bus.bus_wdata   = wdata_q;
endmodule
